// File: rtl/uart_pkg.sv
// Shared UART types: parity mode encodings, parity FSM states and frame length limits.
package uart_pkg;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned LEN_MIN = 5;
  localparam int unsigned LEN_MAX = 9;

  typedef enum logic [1:0] {
    PM_EVEN  = 2'b00,
    PM_ODD   = 2'b01,
    PM_MARK  = 2'b10,
    PM_SPACE = 2'b11
  } par_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } par_state_e;

  // Clamp a requested data length into [LEN_MIN, max_len].
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    if (len < LEN_W'(LEN_MIN)) return LEN_W'(LEN_MIN);
    if (len > max_len)         return max_len;
    return len;
  endfunction

endpackage

// File: rtl/parity_core.sv
// Combinational parity over the low len bits of data, shaped by the parity mode.
module parity_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [LEN_W-1:0]      len,
  input  par_mode_e             mode,
  output logic                  par
);

  logic xor_c;

  always_comb begin
    xor_c = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (LEN_W'(i) < len) xor_c = xor_c ^ data[i];
    end
  end

  always_comb begin
    par = 1'b0;
    unique case (mode)
      PM_EVEN:  par = xor_c;
      PM_ODD:   par = ~xor_c;
      PM_MARK:  par = 1'b1;
      PM_SPACE: par = 1'b0;
      default:  par = 1'b0;
    endcase
  end

endmodule

// File: rtl/parity_gen_chk.sv
// Parity generator/checker: latches a parity bit on load, checks one received
// parity bit against it, and keeps a saturating mismatch count.
module parity_gen_chk
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  rx_par_bit,
  input  logic                  rx_chk_valid,
  input  logic                  err_clr,
  output logic                  par_bit,
  output logic                  par_vld,
  output logic                  par_err,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  par_state_e           state;
  logic [LEN_W-1:0]     len_c;
  logic                 new_par_c;
  logic                 chk_c;
  logic                 mismatch_c;

  assign len_c      = clamp_len(DATA_LEN, LEN_W'(DATA_WIDTH));
  assign chk_c      = (state == ST_ARMED) && rx_chk_valid;
  assign mismatch_c = chk_c && (rx_par_bit != par_bit);

  parity_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .data (P_DATA),
    .len  (len_c),
    .mode (par_mode_e'(PAR_MODE)),
    .par  (new_par_c)
  );

  // The check always compares against the pre-load par_bit; a coincident load then overrides.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      par_bit <= 1'b0;
      par_vld <= 1'b0;
      par_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      par_err <= mismatch_c;

      if (err_clr)                             err_cnt <= '0;
      else if (mismatch_c && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_WIDTH'(1);

      if (Data_Valid) begin
        if (PAR_EN) begin
          state   <= ST_ARMED;
          par_bit <= new_par_c;
          par_vld <= 1'b1;
        end else begin
          state   <= ST_IDLE;
          par_bit <= 1'b0;
          par_vld <= 1'b0;
        end
      end else if (chk_c) begin
        state   <= ST_IDLE;
        par_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_gen_chk.sv
// Self-checking bench for parity_gen_chk: directed scenarios plus randomized traffic vs a reference model.
module tb_parity_gen_chk;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic [3:0]    DATA_LEN;
  logic          PAR_EN;
  logic [1:0]    PAR_MODE;
  logic          rx_par_bit;
  logic          rx_chk_valid;
  logic          err_clr;
  logic          par_bit;
  logic          par_vld;
  logic          par_err;
  logic [CW-1:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  bit m_armed, m_bit, m_err;
  int m_cnt;

  always #5 clk = ~clk;

  parity_gen_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .DATA_LEN     (DATA_LEN),
    .PAR_EN       (PAR_EN),
    .PAR_MODE     (PAR_MODE),
    .rx_par_bit   (rx_par_bit),
    .rx_chk_valid (rx_chk_valid),
    .err_clr      (err_clr),
    .par_bit      (par_bit),
    .par_vld      (par_vld),
    .par_err      (par_err),
    .err_cnt      (err_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Parity from the rules: count ones in the clamped-length field, then apply the mode.
  function automatic bit ref_par(input logic [7:0] d, input int len, input logic [1:0] mode);
    int l, ones;
    logic [7:0] mask;
    l = (len < 5) ? 5 : ((len > DW) ? DW : len);
    mask = 8'((1 << l) - 1);
    ones = $countones(d & mask);
    case (mode)
      2'b00:   return bit'(ones % 2);
      2'b01:   return bit'(1 - (ones % 2));
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    bit chk, mis;
    if (rst) begin
      m_armed = 0; m_bit = 0; m_err = 0; m_cnt = 0;
    end else begin
      chk   = m_armed && rx_chk_valid;
      mis   = chk && (rx_par_bit != m_bit);
      m_err = mis;
      if (err_clr)                              m_cnt = 0;
      else if (mis && m_cnt < (1 << CW) - 1)    m_cnt = m_cnt + 1;
      if (Data_Valid) begin
        m_armed = PAR_EN;
        m_bit   = PAR_EN ? ref_par(P_DATA, int'(DATA_LEN), PAR_MODE) : 1'b0;
      end else if (chk) begin
        m_armed = 0;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare just after it.
  task automatic do_cycle(input bit dv, input logic [7:0] d, input logic [3:0] len,
                          input bit en, input logic [1:0] mode, input bit rxv,
                          input bit rxb, input bit clr, input bit r);
    @(negedge clk);
    Data_Valid = dv; P_DATA = d; DATA_LEN = len; PAR_EN = en; PAR_MODE = mode;
    rx_chk_valid = rxv; rx_par_bit = rxb; err_clr = clr; rst = r;
    @(posedge clk);
    model_step();
    #1;
    check("par_bit", int'(par_bit), int'(m_bit));
    check("par_vld", int'(par_vld), int'(m_armed));
    check("par_err", int'(par_err), int'(m_err));
    check("err_cnt", int'(err_cnt), m_cnt);
  endtask

  task automatic idle_cycle();
    do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    int pulses;
    rst = 1; Data_Valid = 0; P_DATA = '0; DATA_LEN = 4'd8; PAR_EN = 0; PAR_MODE = 0;
    rx_chk_valid = 0; rx_par_bit = 0; err_clr = 0;

    // Reset state
    do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 0, 0, 0, 1);
    check("rst_par_bit", int'(par_bit), 0);
    check("rst_par_vld", int'(par_vld), 0);
    check("rst_err_cnt", int'(err_cnt), 0);

    // A5, length 8, even -> parity 0, valid next cycle
    do_cycle(1, 8'hA5, 4'd8, 1, 2'b00, 0, 0, 0, 0);
    check("a5_even_bit", int'(par_bit), 0);
    check("a5_even_vld", int'(par_vld), 1);

    // A5, length 5, odd -> field 5'h05 -> 1; length 12 clamps to 8
    do_cycle(1, 8'hA5, 4'd5, 1, 2'b01, 0, 0, 0, 0);
    check("a5_len5_odd", int'(par_bit), 1);
    do_cycle(1, 8'hA5, 4'd12, 1, 2'b01, 0, 0, 0, 0);
    check("a5_len12_odd", int'(par_bit), 1);
    do_cycle(1, 8'hA5, 4'd8, 1, 2'b01, 0, 0, 0, 0);
    check("a5_len8_odd", int'(par_bit), 1);
    do_cycle(1, 8'h5A, 4'd3, 1, 2'b00, 0, 0, 0, 0);
    check("len3_clamp5", int'(par_bit), 1);
    do_cycle(1, 8'hA5, 4'd8, 1, 2'b01, 0, 0, 0, 0);

    // Mismatch in ARMED
    do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 1, 0, 0, 0);
    check("mis_err", int'(par_err), 1);
    check("mis_cnt", int'(err_cnt), 1);
    check("mis_vld", int'(par_vld), 0);
    check("mis_bit_held", int'(par_bit), 1);
    idle_cycle();
    check("err_one_cycle", int'(par_err), 0);

    // Saturation at 3 with 5 mismatches
    do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 0, 0, 1, 0);
    check("clr_cnt", int'(err_cnt), 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      do_cycle(1, 8'hA5, 4'd5, 1, 2'b01, 0, 0, 0, 0);
      do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 1, 0, 0, 0);
      if (par_err) pulses++;
    end
    check("sat_cnt", int'(err_cnt), 3);
    check("sat_pulses", pulses, 5);
    do_cycle(1, 8'hA5, 4'd5, 1, 2'b01, 0, 0, 0, 0);
    do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 1, 0, 1, 0);
    check("clr_wins_err", int'(par_err), 1);
    check("clr_wins_cnt", int'(err_cnt), 0);

    // Load coincident with check: old bit 1 vs rx 0, new word parity 0
    do_cycle(1, 8'hA5, 4'd5, 1, 2'b01, 0, 0, 0, 0);
    do_cycle(1, 8'hA5, 4'd8, 1, 2'b00, 1, 0, 0, 0);
    check("coinc_err", int'(par_err), 1);
    check("coinc_bit", int'(par_bit), 0);
    check("coinc_vld", int'(par_vld), 1);

    // Reset beats a pending mismatching check
    do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 1, 1, 0, 1);
    check("rstchk_err", int'(par_err), 0);
    check("rstchk_vld", int'(par_vld), 0);
    check("rstchk_cnt", int'(err_cnt), 0);
    do_cycle(0, 8'h00, 4'd8, 0, 2'b00, 1, 1, 0, 0);
    check("idle_chk_err", int'(par_err), 0);
    check("idle_chk_cnt", int'(err_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      do_cycle(bit'($urandom_range(0, 2) == 0), 8'($urandom), 4'($urandom),
               bit'($urandom_range(0, 3) != 0), 2'($urandom),
               bit'($urandom_range(0, 1)), bit'($urandom),
               bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parity_gen_chk.md
PARITY_GEN_CHK -- requirements
Module: parity_gen_chk

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set the maximum frame data width; the legal range is 5..9.
REQ-002 Parameter CNT_WIDTH, default 8, shall set the width of the parity-error counter.
REQ-003 clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  shall be the reset: synchronous, active-high.
REQ-005 P_DATA  in  DATA_WIDTH  shall carry the data word, LSB-aligned.
REQ-006 Data_Valid  in  1  shall be a single-cycle load strobe for P_DATA and the configuration inputs.
REQ-007 DATA_LEN  in  4  shall give the number of active data bits; it is sampled at load.
REQ-008 PAR_EN  in  1  shall enable parity when high; it is sampled at load.
REQ-009 PAR_MODE  in  2  shall select parity mode: 00 even, 01 odd, 10 mark (1), 11 space (0); it is sampled at load.
REQ-010 rx_par_bit  in  1  shall carry the received parity bit to be checked.
REQ-011 rx_chk_valid  in  1  shall be a single-cycle strobe requesting a check of rx_par_bit.
REQ-012 err_clr  in  1  shall clear the error counter.
REQ-013 par_bit  out  1  shall carry the registered parity bit.
REQ-014 par_vld  out  1  shall be high while par_bit holds a parity value that can be checked.
REQ-015 par_err  out  1  shall pulse high for one cycle on each parity mismatch.
REQ-016 err_cnt  out  CNT_WIDTH  shall hold the saturating mismatch count.

Function
REQ-017 The FSM shall have exactly two states: IDLE and ARMED.
REQ-018 IDLE + Data_Valid + PAR_EN=1 -> ARMED; par_bit and par_vld shall update on the clock edge that samples Data_Valid (visible the following cycle; latency 1).
REQ-019 IDLE + Data_Valid + PAR_EN=0 -> stay IDLE, par_bit<=0, par_vld stays 0.
REQ-020 Effective length L shall be DATA_LEN clamped to the range [5, DATA_WIDTH]; bits P_DATA[DATA_WIDTH-1:L] shall be ignored.
REQ-021 Parity: even = XOR of P_DATA[L-1:0]; odd = its inverse; mark = 1; space = 0.
REQ-022 par_bit shall hold its value between loads; Data_Valid low shall never change it.
REQ-023 ARMED + rx_chk_valid: if rx_par_bit != par_bit, par_err=1 next cycle and err_cnt+1; in either case the FSM shall go to IDLE, with par_vld<=0 and par_bit held.
REQ-024 ARMED + Data_Valid (no check) shall reload par_bit from the new word and remain ARMED (if PAR_EN=1), or go to IDLE with par_bit<=0 (if PAR_EN=0).
REQ-025 ARMED + Data_Valid + rx_chk_valid in the same cycle: the check shall use the old par_bit; the new load shall then apply, leaving the next state and par_vld as defined by the new PAR_EN.
REQ-026 rx_chk_valid in IDLE shall be ignored: no par_err, no count.
REQ-027 err_cnt shall saturate at 2^CNT_WIDTH-1; par_err shall still pulse when err_cnt is saturated.
REQ-028 err_clr shall set err_cnt<=0 next cycle; err_clr coincident with a mismatch shall give err_cnt=0 (clear wins) while par_err still pulses.
REQ-029 par_err shall be registered and high for exactly one cycle per mismatch.

Reset
REQ-030 rst=1 at a clock edge shall force IDLE, par_bit=0, par_vld=0, par_err=0, err_cnt=0.
REQ-031 rst shall take priority over Data_Valid, rx_chk_valid and err_clr in the same cycle; a check pending in ARMED shall be discarded.

Structure
REQ-032 The PAR_MODE encodings, the FSM state type and the length limits (5, 9) shall live in shared package uart_pkg.
REQ-033 The masked-XOR parity function shall be a sub-module named parity_core (combinational; inputs data, L and mode; output bit).
REQ-034 All outputs shall be driven directly from flops.

Verification
REQ-035 The bench shall cover: P_DATA=8'hA5, DATA_LEN=8, mode even, Data_Valid -> next cycle par_bit=0, par_vld=1.
REQ-036 The bench shall cover: P_DATA=8'hA5, DATA_LEN=5, mode odd -> masked 5'h05, par_bit=1; DATA_LEN=12 gives the same result as DATA_LEN=8.
REQ-037 The bench shall cover: ARMED with par_bit=1, rx_chk_valid with rx_par_bit=0 -> par_err one cycle, err_cnt=1, then IDLE with par_vld=0.
REQ-038 The bench shall cover: CNT_WIDTH=2 with 5 mismatches -> err_cnt stops at 3 and par_err pulses 5 times; then err_clr coincident with a mismatch -> err_cnt=0.
REQ-039 The bench shall cover: Data_Valid (new word parity 0) coincident with rx_chk_valid (rx_par_bit=0, old par_bit=1) -> par_err=1, then par_bit=0 and ARMED.
REQ-040 The bench shall cover: rst asserted in ARMED coincident with a mismatching rx_chk_valid -> no par_err and all outputs 0 next cycle; rx_chk_valid in IDLE -> no change.
